// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated 32-bit word store serving MEM-stage loads/stores; optional DMEM_ALIGN_CHECK_EN adds Err.
// Latency: Ack in the (LATENCY+1)th cycle after the accept cycle; backpressure: Ready low (Req ignored) from accept until Ack retires.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        clrn,
  input  logic        Req,
  input  logic        Write_Mem,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic        Ready,
  output logic        Ack,
  output logic [31:0] DataOut
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        Err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;

  logic                r_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdat;
  logic [31:0]         r_dout;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_op_wr;
  logic [ADDR_W-1:0]   w_op_idx;
  logic [31:0]         w_op_wdat;
  logic                w_op_mis;
  logic                w_mem_we;
  logic                w_unused_addr;

  assign w_unused_addr = ^{Address[31:ADDR_W+2], Address[1:0]};

  // State register
  always_ff @(posedge Clock or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (Req) begin
          if (LATENCY == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LAT_INIT;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    Ready        = (r_state == ST_IDLE);
    Ack          = (r_state == ST_RESP);
    w_accept     = (r_state == ST_IDLE) && Req;
    w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
  end

  // With LATENCY==0 the RESP edge is the accept edge, so operands come straight from the ports.
  assign w_op_wr   = (r_state == ST_IDLE) ? Write_Mem : r_wr;
  assign w_op_idx  = (r_state == ST_IDLE) ? Address[ADDR_W+1:2] : r_idx;
  assign w_op_wdat = (r_state == ST_IDLE) ? DataIn : r_wdat;

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_mis;
  logic r_err;

  assign w_op_mis = (r_state == ST_IDLE) ? (Address[1:0] != 2'b00) : r_mis;

  always_ff @(posedge Clock or negedge clrn) begin
    if (!clrn) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mis <= (Address[1:0] != 2'b00);
      end
      if (w_enter_resp) begin
        r_err <= w_op_mis;
      end
    end
  end

  assign Err = r_err;
`else
  assign w_op_mis = 1'b0;
`endif

  always_ff @(posedge Clock or negedge clrn) begin
    if (!clrn) begin
      r_wr   <= 1'b0;
      r_idx  <= '0;
      r_wdat <= 32'h0;
    end else if (w_accept) begin
      r_wr   <= Write_Mem;
      r_idx  <= Address[ADDR_W+1:2];
      r_wdat <= DataIn;
    end
  end

  // Array is deliberately not reset.
  assign w_mem_we = w_enter_resp && w_op_wr && !w_op_mis;

  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
      r_mem[w_op_idx] <= w_op_wdat;
    end
  end

  always_ff @(posedge Clock or negedge clrn) begin
    if (!clrn) begin
      r_dout <= 32'h0;
    end else if (w_enter_resp) begin
      if (w_op_wr) begin
        r_dout <= w_op_wdat;
      end else if (w_op_mis) begin
        r_dout <= 32'h0;
      end else begin
        r_dout <= r_mem[w_op_idx];
      end
    end
  end

  assign DataOut = r_dout;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench: two responders (LATENCY=2 and LATENCY=0) driven with directed loads/stores.
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn;
  logic        a_req, a_wr, a_rdy, a_ack;
  logic [31:0] a_addr, a_din, a_dout;
  logic        b_req, b_wr, b_rdy, b_ack;
  logic [31:0] b_addr, b_din, b_dout;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        a_err, b_err;
`endif

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) u_a (
    .Clock(clk), .clrn(clrn), .Req(a_req), .Write_Mem(a_wr), .Address(a_addr),
    .DataIn(a_din), .Ready(a_rdy), .Ack(a_ack), .DataOut(a_dout)
`ifdef DMEM_ALIGN_CHECK_EN
    , .Err(a_err)
`endif
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT_B)) u_b (
    .Clock(clk), .clrn(clrn), .Req(b_req), .Write_Mem(b_wr), .Address(b_addr),
    .DataIn(b_din), .Ready(b_rdy), .Ack(b_ack), .DataOut(b_dout)
`ifdef DMEM_ALIGN_CHECK_EN
    , .Err(b_err)
`endif
  );

  typedef struct {
    logic [31:0] dat;
    logic        chk_dat;
    logic        err;
    int          ack_cyc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        prev_ack [2];
  logic [31:0] last_dat [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard whenever a responder raises Ack.
  task automatic mon_step(input bit sel, input logic ack, input logic rdy,
                          input logic [31:0] dout, input logic err);
    exp_t e;
    if (ack) begin
      if ((sel ? qb.size() : qa.size()) == 0) begin
        chk(sel ? "B unexpected Ack" : "A unexpected Ack", 32'(ack), 32'd0);
      end else begin
        e = sel ? qb.pop_front() : qa.pop_front();
        chk(sel ? "B Ack cycle" : "A Ack cycle", 32'(cyc), 32'(e.ack_cyc));
        chk(sel ? "B Ready with Ack" : "A Ready with Ack", 32'(rdy), 32'd0);
        chk(sel ? "B Err" : "A Err", 32'(err), 32'(e.err));
        if (e.chk_dat) begin
          chk(sel ? "B DataOut" : "A DataOut", dout, e.dat);
          last_dat[sel] = e.dat;
        end else begin
          last_dat[sel] = dout;
        end
      end
    end else if (prev_ack[sel]) begin
      chk(sel ? "B DataOut held" : "A DataOut held", dout, last_dat[sel]);
    end
    prev_ack[sel] = ack;
  endtask

  always @(negedge clk) begin
    if (!clrn) begin
      prev_ack[0] = 1'b0;
      prev_ack[1] = 1'b0;
    end else begin
`ifdef DMEM_ALIGN_CHECK_EN
      mon_step(1'b0, a_ack, a_rdy, a_dout, a_err);
      mon_step(1'b1, b_ack, b_rdy, b_dout, b_err);
`else
      mon_step(1'b0, a_ack, a_rdy, a_dout, 1'b0);
      mon_step(1'b1, b_ack, b_rdy, b_dout, 1'b0);
`endif
    end
  end

  // Driver: present a request, wait for Ready, push the expected response.
  task automatic issue(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] din, input bit push, input logic [31:0] exp_dat,
                       input logic exp_chk, input logic exp_err, output int acc_cyc);
    exp_t e;
    @(negedge clk);
    if (sel) begin b_req = 1'b1; b_wr = wr; b_addr = addr; b_din = din; end
    else     begin a_req = 1'b1; a_wr = wr; a_addr = addr; a_din = din; end
    for (int i = 0; i < 50 && !(sel ? b_rdy : a_rdy); i++) @(negedge clk);
    acc_cyc = cyc;
    if (!(sel ? b_rdy : a_rdy)) begin
      chk(sel ? "B accept timeout" : "A accept timeout", 32'd0, 32'd1);
    end else if (push) begin
      e.dat = exp_dat; e.chk_dat = exp_chk; e.err = exp_err;
      e.ack_cyc = cyc + (sel ? LAT_B : LAT_A) + 1;
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) b_req = 1'b0; else a_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, acc;
    clrn = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = 32'h0; a_din = 32'h0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_din = 32'h0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("A idle Ready", 32'(a_rdy), 32'd1);
      chk("A idle Ack", 32'(a_ack), 32'd0);
      chk("A idle DataOut", a_dout, 32'h0);
      chk("B idle Ready", 32'(b_rdy), 32'd1);
      chk("B idle Ack", 32'(b_ack), 32'd0);
      chk("B idle DataOut", b_dout, 32'h0);
    end

    // Store then load, LATENCY=2
    issue(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, acc);
    issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, acc);

    // Wrap/alias, with a Req presented during WAIT that must be ignored
    issue(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, acc);
    @(negedge clk);
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h3FC; a_din = 32'h12345678;
    chk("A Ready in WAIT (1)", 32'(a_rdy), 32'd0);
    @(negedge clk);
    chk("A Ready in WAIT (2)", 32'(a_rdy), 32'd0);
    a_req = 1'b0;
    issue(1'b0, 1'b0, 32'h1010, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, acc);

    // LATENCY=0 back-to-back
    issue(1'b1, 1'b1, 32'h0, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0, acc1);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1, 1'b1, 1'b0, acc2);
    chk("B accept spacing", 32'(acc2 - acc1), 32'd2);

    // Reset mid-WAIT drops the pending store
    issue(1'b0, 1'b1, 32'h8, 32'h11, 1'b1, 32'h11, 1'b1, 1'b0, acc);
    issue(1'b0, 1'b1, 32'h8, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0, acc);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("A Ready in reset", 32'(a_rdy), 32'd1);
    chk("A Ack in reset", 32'(a_ack), 32'd0);
    chk("A DataOut cleared", a_dout, 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("A no Ack after reset", 32'(a_ack), 32'd0);
    end
    issue(1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 32'h11, 1'b1, 1'b0, acc);

`ifdef DMEM_ALIGN_CHECK_EN
    issue(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, acc);
    issue(1'b0, 1'b1, 32'h22, 32'h77, 1'b1, 32'h0, 1'b0, 1'b1, acc);
    issue(1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, acc);
    issue(1'b0, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, acc);
`endif

    for (int i = 0; i < 50 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
